led_bus_arbiter: RTL

LED_BUS_ARBITER -- requirements
Module: led_bus_arbiter

---
 rtl/led_bus_arbiter_pkg.sv | 27 ++
 rtl/led_bus_arbiter_rr_arbiter_2.sv | 20 ++
 rtl/led_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/led_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester LED register bus arbiter.
package led_bus_arbiter_pkg;

    localparam int unsigned BUS_W            = 8;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned DEF_HOLD_CYCLES  = 2;
    localparam int unsigned DEF_GAP_CYCLES   = 1;
    localparam int unsigned DEF_NUM_REGS     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] data;
    } bus_word_t;

    // True when addr names one of the implemented LED registers.
    function automatic logic addr_in_range(input logic [BUS_W-1:0] addr,
                                           input int unsigned     num_regs);
        return (32'(addr) < num_regs);
    endfunction

endpackage

// File: rtl/led_bus_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else begin
            grant = req1;
        end
    end

endmodule

// File: rtl/led_bus_arbiter.sv
// Arbitrates MCU-bridge and pattern-sequencer writes onto the LED controller
// bus with a fixed hold window, forced idle gap and out-of-range rejection.
module led_bus_arbiter
    import led_bus_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned NUM_REGS    = DEF_NUM_REGS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [BUS_W-1:0] addr0,
    input  logic [BUS_W-1:0] data0,
    input  logic             req1,
    input  logic [BUS_W-1:0] addr1,
    input  logic [BUS_W-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic [BUS_W-1:0] bus_addr,
    output logic [BUS_W-1:0] bus_data,
    output logic             bus_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rr_ptr, rr_ptr_nxt;   // requester preferred on the next tie
    logic             lat_id, lat_id_nxt;
    logic             lat_bad, lat_bad_nxt;
    bus_word_t        bus_q, bus_nxt;
    logic             valid_nxt, ack0_nxt, ack1_nxt, err_nxt, busy_nxt;

    logic             grant, grant_valid;
    bus_word_t        sel_word;

    rr_arbiter_2 u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (~rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign sel_word = grant ? bus_word_t'({addr1, data1}) : bus_word_t'({addr0, data0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rr_ptr    <= 1'b0;
            lat_id    <= 1'b0;
            lat_bad   <= 1'b0;
            bus_q     <= '0;
            bus_valid <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            lat_id    <= lat_id_nxt;
            lat_bad   <= lat_bad_nxt;
            bus_q     <= bus_nxt;
            bus_valid <= valid_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic; the bus word only moves on a good grant.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rr_ptr_nxt  = rr_ptr;
        lat_id_nxt  = lat_id;
        lat_bad_nxt = lat_bad;
        bus_nxt     = bus_q;
        valid_nxt   = 1'b0;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        err_nxt     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt   = ST_DRIVE;
                    cnt_nxt     = HOLD_LOAD;
                    rr_ptr_nxt  = ~grant;
                    lat_id_nxt  = grant;
                    lat_bad_nxt = ~addr_in_range(sel_word.addr, NUM_REGS);
                    if (addr_in_range(sel_word.addr, NUM_REGS)) begin
                        bus_nxt   = sel_word;
                        valid_nxt = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                    ack0_nxt  = ~lat_id;
                    ack1_nxt  = lat_id;
                    err_nxt   = lat_bad;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    valid_nxt = ~lat_bad;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus_addr = bus_q.addr;
    assign bus_data = bus_q.data;

endmodule
